// File: rtl/ysyx_25040118_pipe_stage.sv
// Pipeline register slice carrying one WIDTH-bit payload per valid/ready
// transfer. MODE selects a plain enable register (0), a forward-registered
// pipe (1) or a two-entry skid buffer whose in_ready comes from a flop (2).
module ysyx_25040118_pipe_stage #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       MODE      = 1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] skid_q;
  logic             skid_valid_q;
  logic             ready_q;

  logic [WIDTH-1:0] main_d;
  logic             valid_d;
  logic [WIDTH-1:0] skid_d;
  logic             skid_valid_d;
  logic [CNT_W-1:0] stall_d;
  logic [1:0]       occ_d;
  logic             in_fire;
  logic             out_fire;

  // Upstream ready: mode 2 uses only flopped state, mode 1 looks through to out_ready
  always_comb begin
    in_ready = 1'b0;
    if (MODE == 0) begin
      in_ready = !rst;
    end else if (MODE == 1) begin
      in_ready = !rst && !flush && (!out_valid || out_ready);
    end else begin
      in_ready = !rst && ready_q && !flush;
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next-state for main and skid entries; flush wins over any handshake
  always_comb begin
    main_d       = out_data;
    valid_d      = out_valid;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (MODE == 0) begin
      if (flush) begin
        valid_d = 1'b0;
      end else begin
        valid_d = in_valid;
        if (in_valid) main_d = in_data;
      end
    end else if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (MODE == 1) begin
      if (in_fire) begin
        main_d  = in_data;
        valid_d = 1'b1;
      end else if (out_fire) begin
        valid_d = 1'b0;
      end
    end else begin
      if (out_fire) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          skid_valid_d = 1'b0;
        end else if (in_fire) begin
          main_d = in_data;
        end else begin
          valid_d = 1'b0;
        end
      end else if (in_fire) begin
        if (!out_valid) begin
          main_d  = in_data;
          valid_d = 1'b1;
        end else begin
          skid_d       = in_data;
          skid_valid_d = 1'b1;
        end
      end
    end
  end

  // Saturating back-pressure count and registered occupancy
  always_comb begin
    stall_d = stall_cnt;
    if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_d = stall_cnt + CNT_W'(1);
    end
    occ_d = 2'(valid_d) + 2'(skid_valid_d);
  end

  // State registers; reset drops every held entry immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data     <= RESET_VAL;
      out_valid    <= 1'b0;
      skid_q       <= RESET_VAL;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      occupancy    <= 2'd0;
      stall_cnt    <= '0;
    end else begin
      out_data     <= main_d;
      out_valid    <= valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      occupancy    <= occ_d;
      stall_cnt    <= stall_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040118_pipe_stage.sv
// Bench for the pipe stage: four instances (mode 0, mode 1, mode 2, and
// mode 1 with a 2-bit stall counter) share one stimulus stream and are
// checked every cycle against a FIFO-level model, plus directed literals.
module tb_ysyx_25040118_pipe_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fl  = 1'b0;
  logic       iv  = 1'b0;
  logic [7:0] id  = 8'h00;
  logic       ordy = 1'b0;

  logic       rdy [4];
  logic       ov  [4];
  logic [7:0] od  [4];
  logic [1:0] occ [4];
  logic [15:0] st0, st1, st2;
  logic [1:0]  st3;
  logic [15:0] st_all [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25040118_pipe_stage #(.WIDTH(8), .RESET_VAL(8'h00), .MODE(0), .CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(rdy[0]), .in_data(id),
    .out_valid(ov[0]), .out_ready(ordy), .out_data(od[0]), .occupancy(occ[0]), .stall_cnt(st0));
  ysyx_25040118_pipe_stage #(.WIDTH(8), .RESET_VAL(8'h00), .MODE(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(rdy[1]), .in_data(id),
    .out_valid(ov[1]), .out_ready(ordy), .out_data(od[1]), .occupancy(occ[1]), .stall_cnt(st1));
  ysyx_25040118_pipe_stage #(.WIDTH(8), .RESET_VAL(8'hE5), .MODE(2), .CNT_W(16)) d2 (
    .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(rdy[2]), .in_data(id),
    .out_valid(ov[2]), .out_ready(ordy), .out_data(od[2]), .occupancy(occ[2]), .stall_cnt(st2));
  ysyx_25040118_pipe_stage #(.WIDTH(8), .RESET_VAL(8'h3C), .MODE(1), .CNT_W(2)) d3 (
    .clk(clk), .rst(rst), .flush(fl), .in_valid(iv), .in_ready(rdy[3]), .in_data(id),
    .out_valid(ov[3]), .out_ready(ordy), .out_data(od[3]), .occupancy(occ[3]), .stall_cnt(st3));

  assign st_all[0] = st0;
  assign st_all[1] = st1;
  assign st_all[2] = st2;
  assign st_all[3] = 16'(st3);

  // Model: each instance is a FIFO of capacity 1 (modes 0/1) or 2 (mode 2)
  int         mode_m [4] = '{0, 1, 2, 1};
  logic [7:0] rv_m   [4] = '{8'h00, 8'h00, 8'hE5, 8'h3C};
  int         smax   [4] = '{65535, 65535, 65535, 3};
  int         cnt    [4];
  logic [7:0] ent    [4][2];
  logic [7:0] last   [4];
  int         stl    [4];

  function automatic logic exp_rdy(input int i);
    if (rst) return 1'b0;
    if (mode_m[i] == 0) return 1'b1;
    if (fl) return 1'b0;
    if (mode_m[i] == 1) return (cnt[i] == 0) || ordy;
    return cnt[i] < 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i]  = 0;
        stl[i]  = 0;
        last[i] = rv_m[i];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic vm, ofire, ifire;
        vm    = cnt[i] > 0;
        ofire = vm && ordy;
        ifire = iv && exp_rdy(i);
        if (vm && !ordy && stl[i] < smax[i]) stl[i] = stl[i] + 1;
        if (mode_m[i] == 0) begin
          if (fl) cnt[i] = 0;
          else begin
            cnt[i] = iv ? 1 : 0;
            if (iv) ent[i][0] = id;
          end
        end else if (fl) begin
          cnt[i] = 0;
        end else begin
          if (ofire) begin
            ent[i][0] = ent[i][1];
            cnt[i]    = cnt[i] - 1;
          end
          if (ifire) begin
            ent[i][cnt[i]] = id;
            cnt[i]         = cnt[i] + 1;
          end
        end
        if (cnt[i] > 0) last[i] = ent[i][0];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("model_rdy%0d", i), 32'(rdy[i]), 32'(exp_rdy(i)));
      chk($sformatf("model_valid%0d", i), 32'(ov[i]), 32'(cnt[i] > 0));
      chk($sformatf("model_data%0d", i), 32'(od[i]), 32'(last[i]));
      chk($sformatf("model_occ%0d", i), 32'(occ[i]), 32'(cnt[i]));
      chk($sformatf("model_stall%0d", i), 32'(st_all[i]), 32'(stl[i]));
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    iv = v; id = d; ordy = r; fl = f;
    @(negedge clk);
  endtask

  int sat_exp [7] = '{0, 1, 2, 3, 3, 3, 3};

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data2", 32'(od[2]), 32'h0E5);
    chk("rst_rdy2", 32'(rdy[2]), 32'h0);
    chk("rst_rdy1", 32'(rdy[1]), 32'h0);
    chk("rst_occ2", 32'(occ[2]), 32'h0);
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    chk("rel_rdy2", 32'(rdy[2]), 32'h1);
    chk("rel_rdy1", 32'(rdy[1]), 32'h1);

    // Mode 1 streaming at full throughput
    step(1'b1, 8'h11, 1'b1, 1'b0);
    chk("m1_rdy_a", 32'(rdy[1]), 32'h1);
    step(1'b1, 8'h22, 1'b1, 1'b0);
    chk("m1_d11", 32'(od[1]), 32'h11);
    chk("m1_rdy_b", 32'(rdy[1]), 32'h1);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    chk("m1_d22", 32'(od[1]), 32'h22);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("m1_d33", 32'(od[1]), 32'h33);
    chk("m1_stall", 32'(st1), 32'h0);

    // Mode 2 back-pressure into the skid entry
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    chk("m2_head_a", 32'(od[2]), 32'h0A);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    chk("m2_occ2", 32'(occ[2]), 32'h2);
    chk("m2_rdy_full", 32'(rdy[2]), 32'h0);
    step(1'b1, 8'h0C, 1'b1, 1'b0);
    chk("m2_out_a", 32'(od[2]), 32'h0A);
    step(1'b1, 8'h0C, 1'b1, 1'b0);
    chk("m2_out_b", 32'(od[2]), 32'h0B);
    chk("m2_rdy_free", 32'(rdy[2]), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("m2_out_c", 32'(od[2]), 32'h0C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("m2_empty", 32'(ov[2]), 32'h0);

    // Flush beats a pending upstream transfer
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    chk("fl_rdy1", 32'(rdy[1]), 32'h0);
    chk("fl_hold55", 32'(od[1]), 32'h55);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fl_valid1", 32'(ov[1]), 32'h0);
    chk("fl_keep55", 32'(od[1]), 32'h55);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fl_no66", 32'(od[1]), 32'h55);

    // Asynchronous reset with the skid buffer full
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ar_occ2", 32'(occ[2]), 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(ov[2]), 32'h0);
    chk("ar_occ0", 32'(occ[2]), 32'h0);
    chk("ar_data", 32'(od[2]), 32'h0E5);
    chk("ar_rdy", 32'(rdy[2]), 32'h0);
    @(posedge clk); #1; rst = 1'b0; @(negedge clk);
    chk("ar_rdy_rel", 32'(rdy[2]), 32'h1);

    // Saturation of the 2-bit stall counter
    step(1'b1, 8'h77, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("sat_%0d", k), 32'(st3), 32'(sat_exp[k]));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Mode 0 pulses with downstream stalled
    step(1'b1, 8'h07, 1'b0, 1'b0);
    chk("m0_rdy", 32'(rdy[0]), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("m0_v7", 32'(ov[0]), 32'h1);
    chk("m0_d7", 32'(od[0]), 32'h07);
    step(1'b1, 8'h09, 1'b0, 1'b0);
    chk("m0_gap", 32'(ov[0]), 32'h0);
    chk("m0_st2", 32'(st0), 32'h2);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("m0_d9", 32'(od[0]), 32'h09);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("m0_st3", 32'(st0), 32'h3);
    chk("m0_hold9", 32'(od[0]), 32'h09);
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    chk("m0_fl_rdy", 32'(rdy[0]), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("m0_fl_valid", 32'(ov[0]), 32'h0);

    // Mixed traffic checked by the model alone
    for (int k = 0; k < 80; k++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25040118_pipe_stage.md
Name: ysyx_25040118_pipe_stage

Overview:
- Parametrised pipeline register slice: the handshake-capable successor to the team's plain enable register.
- Carries one WIDTH-bit payload per transfer between two pipeline stages using valid/ready.
- Three build-time modes: enable-register, forward-registered pipe, and full skid buffer. Also provides synchronous flush, an occupancy output and a saturating back-pressure counter.
- Instantiated between NPC stages (IFU→IDU, IDU→EXU, EXU→LSU) and on bus response paths.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- RESET_VAL, 0, out_data value after reset.
- MODE, 1, 0 = enable register (no back-pressure); 1 = forward-registered pipe; 2 = skid buffer (in_ready driven from a flop).
- CNT_W, 16, width of stall_cnt (≥1).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous, active-high reset.
- flush, input, 1, synchronous kill of all buffered entries.
- in_valid, input, 1, upstream payload valid.
- in_ready, output, 1, block can accept this cycle.
- in_data, input, WIDTH, upstream payload.
- out_valid, output, 1, downstream payload valid.
- out_ready, input, 1, downstream accepts.
- out_data, output, WIDTH, downstream payload.
- occupancy, output, 2, number of held entries (0–2).
- stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset: asynchronous, active-high; all state clears immediately on rst assertion.
  - out_data = RESET_VAL, skid data = RESET_VAL.
  - out_valid = 0, skid_valid = 0, occupancy = 0, stall_cnt = 0.
  - in_ready = 0 while rst is high.
  - Reset mid-transfer drops every held entry; no partial state survives.
- Flush:
  - Sampled at clk edge; next cycle out_valid = 0 and skid_valid = 0.
  - Data registers keep their values.
  - While flush = 1, in_ready = 0 (modes 1/2), so no handshake is accepted and lost.
  - flush has priority over in_valid and out_ready in the same cycle.
  - stall_cnt is not cleared by flush.
- MODE 0 (enable register):
  - in_ready = !rst, independent of out_ready.
  - Each edge: out_valid <= in_valid; if in_valid, out_data <= in_data, else out_data holds.
  - out_ready is ignored for the data path; one-cycle latency.
  - In MODE 0, flush clears out_valid and in_ready stays 1.
- MODE 1 (pipe):
  - in_ready = !rst & !flush & (!out_valid | out_ready). This is a combinational path from out_ready.
  - in_fire: out_data <= in_data, out_valid <= 1.
  - Else if out_fire: out_valid <= 0.
  - Latency 1 cycle; full throughput when out_ready stays high.
  - Simultaneous in_fire and out_fire: new payload replaces the old one, out_valid stays 1.
- MODE 2 (skid):
  - in_ready = ready_q & !flush; ready_q is a flop equal to !skid_valid, and is 1 out of reset.
  - There is no combinational path from out_ready to in_ready.
  - in_fire when the main register is empty or out_fire: payload goes to the main register.
  - in_fire when the main register is full and not out_fire: payload goes to skid, skid_valid <= 1.
  - out_fire with skid_valid: main <= skid, skid_valid <= 0.
  - Skid full implies in_ready = 0 next cycle.
  - Ordering is strictly FIFO; no duplication and no loss.
- occupancy: out_valid + skid_valid; max 1 in modes 0/1, max 2 in mode 2.
- stall_cnt:
  - Increments on each edge where out_valid & !out_ready, in all modes.
  - Saturates at 2^CNT_W−1; no wrap.
- Outputs out_valid, out_data, occupancy and stall_cnt are all driven directly from flops.

Test Plan:
- Reset: assert rst asynchronously mid-stream, MODE 2, occupancy 2 → out_valid=0, occupancy=0, out_data=RESET_VAL, in_ready=0 immediately; in_ready=1 on the first cycle after release.
- MODE 1 streaming: send 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 → out_data 0x11/0x22/0x33 one cycle later each, in_ready constant 1, stall_cnt=0.
- MODE 2 back-pressure: out_ready=0 while sending 0xA, 0xB, 0xC → 0xA held in main, 0xB in skid, occupancy=2, in_ready=0 so 0xC is not accepted. Then out_ready=1 → outputs 0xA, 0xB, then 0xC, in order, with no loss.
- Flush priority: MODE 1 holding 0x55, flush=1 with in_valid=1 and in_data=0x66 → in_ready=0 that cycle, out_valid=0 next cycle, 0x66 never appears.
- stall_cnt saturation: CNT_W=2, out_valid=1, out_ready=0 for 6 cycles → stall_cnt counts 1, 2, 3, 3, 3, 3.
- MODE 0: in_valid pulses carrying 0x7 then 0x9 with out_ready=0 → out_valid follows in_valid one cycle later, out_data=0x9, in_ready stays 1, stall_cnt increments only on cycles where out_valid=1.
